rf_dump_reader: RTL

- Debug read-out engine for the multicycle core's 32x32 register file.
- On a start pulse it stalls the core, then borrows read port 1 (a1/rd1).
- Walks a register index range and streams each value out on a valid/ready interface, for the debug/trace unit.
- It is the consumer of register-file contents; the core's normal datapath remains the only writer.

---
 rtl/rf_dbg_pkg.sv | 54 +++++
 rtl/rf_dump_reader.sv | 115 +++++++++++
 2 files changed

// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug read-out path: sizes used by the
// register file, the core's a1 override mux and the dump reader, plus the reader's states.
`timescale 1ns/1ps
package rf_dbg_pkg;

    localparam int NREG = 32;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        READ,
        SEND,
        FIN
    } state_t;

    typedef struct packed {
        logic halt_req;
        logic rf_sel;
        logic out_valid;
        logic busy;
        logic done;
    } flags_t;

    // Output flags that hold while the FSM sits in a given state; loaded together with the state.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            HALT: begin
                f.halt_req = 1'b1;
                f.busy     = 1'b1;
            end
            READ: begin
                f.halt_req = 1'b1;
                f.rf_sel   = 1'b1;
                f.busy     = 1'b1;
            end
            SEND: begin
                f.halt_req  = 1'b1;
                f.out_valid = 1'b1;
                f.busy      = 1'b1;
            end
            FIN: begin
                f.done = 1'b1;
                f.busy = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rf_dump_reader.sv
// Debug dump engine: halts the core, borrows read port 1 and streams a wrapping range of
// register-file entries out over valid/ready, one word per READ/SEND pair.
//
//  state | meaning
//  IDLE  | waiting for start; all outputs low
//  HALT  | halt_req raised, waiting for the core to report frozen
//  READ  | a1 overridden with the current index; capture rd1 once halt_ack holds
//  SEND  | captured word presented on out_*, held until out_ready
//  FIN   | one-cycle done pulse, core released
`timescale 1ns/1ps
module rf_dump_reader
    import rf_dbg_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   first_idx,
    input  logic [AW-1:0]   last_idx,
    output logic            halt_req,
    input  logic            halt_ack,
    output logic            rf_sel,
    output logic [AW-1:0]   rf_a,
    input  logic [XLEN-1:0] rf_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [AW-1:0]   out_idx,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    state_t          r_state;
    flags_t          r_flags;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_last;
    logic [AW-1:0]   r_out_idx;
    logic [XLEN-1:0] r_out_data;
    logic            r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_flags    <= '0;
            r_idx      <= '0;
            r_last     <= '0;
            r_out_idx  <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (abort) begin
            // Abort beats every transition, including start in IDLE and a same-cycle handshake.
            r_state <= IDLE;
            r_flags <= state_flags(IDLE);
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= first_idx;
                        r_last  <= last_idx;
                        r_state <= HALT;
                        r_flags <= state_flags(HALT);
                    end
                end
                HALT: begin
                    if (halt_ack) begin
                        r_state <= READ;
                        r_flags <= state_flags(READ);
                    end
                end
                READ: begin
                    // A dropped ack means the core slipped; nothing read this cycle is trusted.
                    if (halt_ack) begin
                        r_out_data <= rf_rd;
                        r_out_idx  <= r_idx;
                        r_out_last <= (r_idx == r_last);
                        r_state    <= SEND;
                        r_flags    <= state_flags(SEND);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state <= FIN;
                            r_flags <= state_flags(FIN);
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= READ;
                            r_flags <= state_flags(READ);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_flags <= state_flags(IDLE);
                end
                default: begin
                    r_state <= IDLE;
                    r_flags <= state_flags(IDLE);
                end
            endcase
        end
    end

    assign halt_req  = r_flags.halt_req;
    assign rf_sel    = r_flags.rf_sel;
    assign out_valid = r_flags.out_valid;
    assign busy      = r_flags.busy;
    assign done      = r_flags.done;
    assign rf_a      = r_idx;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
